// File: rtl/hssi_lane_reset_seq.sv
// Per-lane HSSI reset/bring-up sequencer: ordered TX/RX analog and digital reset release plus init handshake.
// Optional watchdog on wait states is compiled in with `define HSSI_RST_SEQ_TIMEOUT_EN.
module hssi_lane_reset_seq #(
  parameter int unsigned NUM_LN          = 4,
  parameter int unsigned ANA_RST_CYC     = 16,
  parameter int unsigned DIG_RST_CYC     = 8,
  parameter int unsigned LOCK_STABLE_CYC = 64,
  parameter int unsigned TIMEOUT_CYC     = 65536
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              f2a_tx_pll_locked,
  input  logic              f2a_tx_cal_busy,
  input  logic              f2a_rx_cal_busy,
  input  logic [NUM_LN-1:0] f2a_rx_is_lockedtodata,
  input  logic              f2a_init_done,
  output logic [NUM_LN-1:0] a2f_tx_analogreset,
  output logic [NUM_LN-1:0] a2f_tx_digitalreset,
  output logic [NUM_LN-1:0] a2f_rx_analogreset,
  output logic [NUM_LN-1:0] a2f_rx_digitalreset,
  output logic              a2f_init_start,
  output logic              ready,
  output logic              timeout_err,
  output logic [3:0]        state_o
);

  localparam int unsigned MAX_AD  = (ANA_RST_CYC > DIG_RST_CYC) ? ANA_RST_CYC : DIG_RST_CYC;
  localparam int unsigned MAX_ADL = (MAX_AD > LOCK_STABLE_CYC) ? MAX_AD : LOCK_STABLE_CYC;
  localparam int unsigned MAX_CYC = (MAX_ADL > TIMEOUT_CYC) ? MAX_ADL : TIMEOUT_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned SYNC_W  = NUM_LN + 4;

  localparam logic [CNT_W-1:0] ANA_LAST  = CNT_W'(ANA_RST_CYC - 1);
  localparam logic [CNT_W-1:0] ANA_HOLD  = CNT_W'(ANA_RST_CYC);
  localparam logic [CNT_W-1:0] DIG_LAST  = CNT_W'(DIG_RST_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYC - 1);

  // With all status ideal, IDLE to READY takes
  // 2*ANA_RST_CYC + DIG_RST_CYC + LOCK_STABLE_CYC + 7 cycles:
  // IDLE 1, TX_PLL 1, RX_ANA release cycle 1, RX_DIG 2, INIT 2.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_TX_ANA = 4'd1,
    S_TX_PLL = 4'd2,
    S_TX_DIG = 4'd3,
    S_RX_ANA = 4'd4,
    S_RX_CDR = 4'd5,
    S_RX_DIG = 4'd6,
    S_INIT   = 4'd7,
    S_READY  = 4'd8
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              enter;
  logic              tx_ana_q, tx_ana_d;
  logic              tx_dig_q, tx_dig_d;
  logic              rx_ana_q, rx_ana_d;
  logic              rx_dig_q, rx_dig_d;
  logic              init_start_q, init_start_d;
  logic              ready_q, ready_d;

  logic [SYNC_W-1:0] sync_meta, sync_q;
  logic              pll_locked, tx_cal_busy, rx_cal_busy, init_done, rx_locked_all;

  // Two-flop synchronizers for every asynchronous status input.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= {f2a_tx_pll_locked, f2a_tx_cal_busy, f2a_rx_cal_busy, f2a_init_done,
                    f2a_rx_is_lockedtodata};
      sync_q    <= sync_meta;
    end
  end

  assign pll_locked    = sync_q[SYNC_W-1];
  assign tx_cal_busy   = sync_q[SYNC_W-2];
  assign rx_cal_busy   = sync_q[SYNC_W-3];
  assign init_done     = sync_q[SYNC_W-4];
  assign rx_locked_all = &sync_q[NUM_LN-1:0];

`ifdef HSSI_RST_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] wd_cnt, wd_cnt_d;
  logic             timeout_q, timeout_d;
  logic             wd_watched;

  assign wd_watched = (state == S_TX_ANA) || (state == S_TX_PLL) || (state == S_RX_ANA) ||
                      (state == S_RX_CDR) || (state == S_INIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt    <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      tx_ana_q     <= 1'b1;
      tx_dig_q     <= 1'b1;
      rx_ana_q     <= 1'b1;
      rx_dig_q     <= 1'b1;
      init_start_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      tx_ana_q     <= tx_ana_d;
      tx_dig_q     <= tx_dig_d;
      rx_ana_q     <= rx_ana_d;
      rx_dig_q     <= rx_dig_d;
      init_start_q <= init_start_d;
      ready_q      <= ready_d;
    end
  end

  // Next state; 'enter' marks any state (re)entry and clears the counters.
  always_comb begin
    state_d      = state;
    cnt_d        = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    enter        = 1'b0;
    init_start_d = 1'b0;
`ifdef HSSI_RST_SEQ_TIMEOUT_EN
    timeout_d    = timeout_q;
`endif

    case (state)
      S_IDLE: begin
        state_d = S_TX_ANA;
        enter   = 1'b1;
      end
      S_TX_ANA: begin
        if ((cnt >= ANA_LAST) && !tx_cal_busy) begin
          state_d = S_TX_PLL;
          enter   = 1'b1;
        end
      end
      S_TX_PLL: begin
        if (pll_locked) begin
          state_d = S_TX_DIG;
          enter   = 1'b1;
        end
      end
      S_TX_DIG: begin
        if (!pll_locked) begin
          state_d = S_TX_PLL;
          enter   = 1'b1;
        end else if (cnt >= DIG_LAST) begin
          state_d = S_RX_ANA;
          enter   = 1'b1;
        end
      end
      S_RX_ANA: begin
        if ((cnt >= ANA_HOLD) && !rx_cal_busy) begin
          state_d = S_RX_CDR;
          enter   = 1'b1;
        end
      end
      S_RX_CDR: begin
        if (!rx_locked_all) begin
          cnt_d = '0;
        end else if (cnt >= LOCK_LAST) begin
          state_d = S_RX_DIG;
          enter   = 1'b1;
        end
      end
      S_RX_DIG: begin
        if (cnt >= CNT_W'(1)) begin
          state_d      = S_INIT;
          enter        = 1'b1;
          init_start_d = 1'b1;
        end
      end
      S_INIT: begin
        // A stale init_done from a previous run is ignored for the first INIT cycle.
        if (init_done && (cnt >= CNT_W'(1))) begin
          state_d = S_READY;
          enter   = 1'b1;
        end
      end
      S_READY: begin
        if (!pll_locked) begin
          state_d = S_TX_ANA;
          enter   = 1'b1;
        end else if (!rx_locked_all) begin
          state_d = S_RX_CDR;
          enter   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        enter   = 1'b1;
      end
    endcase

`ifdef HSSI_RST_SEQ_TIMEOUT_EN
    if (wd_watched && !enter && (wd_cnt >= WD_LAST)) begin
      state_d   = S_TX_ANA;
      enter     = 1'b1;
      timeout_d = 1'b1;
    end
`endif

    if (restart) begin
      state_d      = S_IDLE;
      enter        = 1'b1;
      init_start_d = 1'b0;
`ifdef HSSI_RST_SEQ_TIMEOUT_EN
      timeout_d    = 1'b0;
`endif
    end

    if (enter) begin
      cnt_d = '0;
    end

`ifdef HSSI_RST_SEQ_TIMEOUT_EN
    if (enter) begin
      wd_cnt_d = '0;
    end else begin
      wd_cnt_d = (wd_cnt == '1) ? wd_cnt : wd_cnt + CNT_W'(1);
    end
`endif

    // Outputs are decoded from the next state so they switch on the same edge as the state.
    tx_ana_d = (state_d == S_IDLE) || (state_d == S_TX_ANA);
    tx_dig_d = tx_ana_d || (state_d == S_TX_PLL) || (state_d == S_TX_DIG);
    rx_ana_d = tx_dig_d || ((state_d == S_RX_ANA) && (cnt_d < ANA_HOLD));
    rx_dig_d = tx_dig_d || (state_d == S_RX_ANA) || (state_d == S_RX_CDR);
    ready_d  = (state_d == S_READY);
  end

  assign a2f_tx_analogreset  = {NUM_LN{tx_ana_q}};
  assign a2f_tx_digitalreset = {NUM_LN{tx_dig_q}};
  assign a2f_rx_analogreset  = {NUM_LN{rx_ana_q}};
  assign a2f_rx_digitalreset = {NUM_LN{rx_dig_q}};
  assign a2f_init_start      = init_start_q;
  assign ready               = ready_q;
  assign state_o             = state;

endmodule

// File: tb/tb_hssi_lane_reset_seq.sv
// Directed bench for hssi_lane_reset_seq: bring-up ordering, lock waits, CDR recovery, reset and watchdog.
module tb_hssi_lane_reset_seq;

  localparam int unsigned NUM_LN      = 4;
  localparam int unsigned TIMEOUT_CYC = 1000;

  logic              clk = 1'b0;
  logic              reset;
  logic              restart;
  logic              pll_locked;
  logic              tx_cal_busy;
  logic              rx_cal_busy;
  logic              init_done;
  logic [NUM_LN-1:0] lock;
  logic [NUM_LN-1:0] tx_ana, tx_dig, rx_ana, rx_dig;
  logic              init_start, ready, timeout_err;
  logic [3:0]        state_o;

  int checks = 0;
  int errors = 0;
  int cyc, pulses, n, t_mark;
  int rel_tx_ana, rel_tx_dig, rel_rx_ana, rel_rx_dig;

  always #5 clk = ~clk;

  hssi_lane_reset_seq #(
    .NUM_LN          (NUM_LN),
    .ANA_RST_CYC     (16),
    .DIG_RST_CYC     (8),
    .LOCK_STABLE_CYC (64),
    .TIMEOUT_CYC     (TIMEOUT_CYC)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .restart                (restart),
    .f2a_tx_pll_locked      (pll_locked),
    .f2a_tx_cal_busy        (tx_cal_busy),
    .f2a_rx_cal_busy        (rx_cal_busy),
    .f2a_rx_is_lockedtodata (lock),
    .f2a_init_done          (init_done),
    .a2f_tx_analogreset     (tx_ana),
    .a2f_tx_digitalreset    (tx_dig),
    .a2f_rx_analogreset     (rx_ana),
    .a2f_rx_digitalreset    (rx_dig),
    .a2f_init_start         (init_start),
    .ready                  (ready),
    .timeout_err            (timeout_err),
    .state_o                (state_o)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_trace();
    cyc        = 0;
    pulses     = 0;
    rel_tx_ana = -1;
    rel_tx_dig = -1;
    rel_rx_ana = -1;
    rel_rx_dig = -1;
  endtask

  // One clock; observe on the falling edge and log first release of each reset bus.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (init_start === 1'b1) pulses++;
    if (tx_ana === '0 && rel_tx_ana < 0) rel_tx_ana = cyc;
    if (tx_dig === '0 && rel_tx_dig < 0) rel_tx_dig = cyc;
    if (rx_ana === '0 && rel_rx_ana < 0) rel_rx_ana = cyc;
    if (rx_dig === '0 && rel_rx_dig < 0) rel_rx_dig = cyc;
  endtask

  task automatic run_until(input logic [3:0] target, input int bound);
    n = 0;
    while (state_o !== target && n < bound) begin
      step();
      n++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_time_limit observed=expired expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset       = 1'b1;
    restart     = 1'b0;
    pll_locked  = 1'b1;
    tx_cal_busy = 1'b0;
    rx_cal_busy = 1'b0;
    init_done   = 1'b1;
    lock        = 4'hF;
    clear_trace();
    repeat (3) @(negedge clk);

    check("rst_tx_ana", int'(tx_ana), 15);
    check("rst_tx_dig", int'(tx_dig), 15);
    check("rst_rx_ana", int'(rx_ana), 15);
    check("rst_rx_dig", int'(rx_dig), 15);
    check("rst_init_start", int'(init_start), 0);
    check("rst_ready", int'(ready), 0);
    check("rst_timeout", int'(timeout_err), 0);
    check("rst_state", int'(state_o), 0);

    // Ideal bring-up with init_done already high.
    reset = 1'b0;
    clear_trace();
    step();
    check("first_state", int'(state_o), 1);
    check("first_tx_ana", int'(tx_ana), 15);
    run_until(4'd8, 300);
    t_mark = cyc;
    repeat (3) step();
    check("ideal_ready_cyc", t_mark, 111);
    check("ideal_rel_tx_ana", rel_tx_ana, 17);
    check("ideal_rel_tx_dig", rel_tx_dig, 26);
    check("ideal_rel_rx_ana", rel_rx_ana, 42);
    check("ideal_rel_rx_dig", rel_rx_dig, 107);
    check("ideal_pulses", pulses, 1);
    check("ideal_state", int'(state_o), 8);
    check("ideal_ready", int'(ready), 1);
    check("ideal_rx_dig", int'(rx_dig), 0);

    // Restart, then init_done arrives 10 cycles after the init pulse.
    restart   = 1'b1;
    init_done = 1'b0;
    step();
    restart = 1'b0;
    check("restart_state", int'(state_o), 0);
    check("restart_ready", int'(ready), 0);
    check("restart_rx_dig", int'(rx_dig), 15);
    clear_trace();
    run_until(4'd7, 200);
    check("init_entry_cyc", cyc, 109);
    check("init_start_high", int'(init_start), 1);
    repeat (10) step();
    check("init_wait_state", int'(state_o), 7);
    check("init_start_low", int'(init_start), 0);
    init_done = 1'b1;
    run_until(4'd8, 20);
    check("init_done_latency", n, 3);
    check("init_pulses", pulses, 1);

    // PLL lock withheld for 500 cycles.
    restart    = 1'b1;
    pll_locked = 1'b0;
    step();
    restart = 1'b0;
    clear_trace();
    repeat (500) step();
    check("pll_wait_state", int'(state_o), 2);
    check("pll_wait_tx_dig", int'(tx_dig), 15);
    check("pll_wait_tx_ana", int'(tx_ana), 0);
    pll_locked = 1'b1;
    clear_trace();
    run_until(4'd8, 200);
    check("pll_to_ready_cyc", cyc, 96);

    // Lane 2 CDR lock toggling every 40 cycles.
    restart = 1'b1;
    lock    = 4'hB;
    step();
    restart = 1'b0;
    clear_trace();
    for (int i = 0; i < 10; i++) begin
      lock[2] = (i % 2 == 1);
      repeat (40) step();
    end
    lock[2] = 1'b0;
    repeat (5) step();
    check("cdr_toggle_state", int'(state_o), 5);
    check("cdr_toggle_rx_dig", int'(rx_dig), 15);
    check("cdr_toggle_rx_ana", int'(rx_ana), 0);
    check("cdr_toggle_tx_dig", int'(tx_dig), 0);
    lock = 4'hF;
    clear_trace();
    run_until(4'd6, 200);
    check("cdr_stable_cyc", cyc, 66);
    check("cdr_rx_dig_rel", int'(rx_dig), 0);
    run_until(4'd8, 20);
    check("cdr_ready", int'(ready), 1);

    // Lane 0 loses lock for 5 cycles while READY.
    lock = 4'hE;
    step();
    step();
    check("drop_ready_hold", int'(ready), 1);
    step();
    check("drop_ready", int'(ready), 0);
    check("drop_state", int'(state_o), 5);
    check("drop_rx_dig", int'(rx_dig), 15);
    check("drop_tx_ana", int'(tx_ana), 0);
    check("drop_tx_dig", int'(tx_dig), 0);
    step();
    step();
    lock = 4'hF;
    clear_trace();
    run_until(4'd8, 200);
    check("recover_cyc", cyc, 70);
    check("recover_pulses", pulses, 1);

    // Synchronous reset asserted in TX_DIG.
    restart = 1'b1;
    step();
    restart = 1'b0;
    run_until(4'd3, 100);
    check("txdig_state", int'(state_o), 3);
    check("txdig_tx_dig", int'(tx_dig), 15);
    check("txdig_tx_ana", int'(tx_ana), 0);
    reset = 1'b1;
    step();
    check("midrst_tx_ana", int'(tx_ana), 15);
    check("midrst_tx_dig", int'(tx_dig), 15);
    check("midrst_rx_ana", int'(rx_ana), 15);
    check("midrst_rx_dig", int'(rx_dig), 15);
    check("midrst_state", int'(state_o), 0);
    check("midrst_ready", int'(ready), 0);
    check("midrst_init_start", int'(init_start), 0);
    reset = 1'b0;

`ifdef HSSI_RST_SEQ_TIMEOUT_EN
    // Watchdog expiry in INIT, cleared by restart.
    init_done = 1'b0;
    restart   = 1'b1;
    step();
    restart = 1'b0;
    run_until(4'd7, 200);
    check("wd_init_state", int'(state_o), 7);
    repeat (999) step();
    check("wd_pre_state", int'(state_o), 7);
    check("wd_pre_err", int'(timeout_err), 0);
    step();
    check("wd_err", int'(timeout_err), 1);
    check("wd_state", int'(state_o), 1);
    check("wd_tx_ana", int'(tx_ana), 15);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("wd_clear_err", int'(timeout_err), 0);
    check("wd_clear_state", int'(state_o), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
